// File: rtl/limn2600_bus_pkg.sv
// Shared types for the Limn2600 bus master: access sizes, FSM state codes,
// the latched request record and the accept-time legality check.
// Optional feature macro: LIMN2600_BUS_RMW_EN (sub-word stores via read-modify-write).
package limn2600_bus_pkg;

    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // FSM state encoding, kept as plain constants so legacy tools can read it
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_RD     = 3'd1;
    localparam state_t ST_WR     = 3'd2;
    localparam state_t ST_RMW_RD = 3'd3;
    localparam state_t ST_RMW_WR = 3'd4;
    localparam state_t ST_RESP   = 3'd5;

    typedef struct packed {
        logic                  we;
        size_e                 size;
        logic                  sgn;
        logic [BUS_DATA_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } req_t;

    // True when a request must be answered with an error and no bus cycle
    function automatic logic req_bad(input size_e sz, input logic [1:0] a, input logic we);
        logic bad;
        bad = 1'b0;
        case (sz)
            SZ_HALF: bad = a[0];
            SZ_WORD: bad = (a != 2'b00);
            SZ_ILL:  bad = 1'b1;
            default: bad = 1'b0;
        endcase
`ifndef LIMN2600_BUS_RMW_EN
        // without RMW there is no way to write a partial word
        if (we && (sz == SZ_BYTE || sz == SZ_HALF))
            bad = 1'b1;
`else
        if (we && 1'b0)
            bad = 1'b1;
`endif
        return bad;
    endfunction

endpackage

// File: rtl/limn2600_lane_align.sv
// Combinational byte-lane handling: load extract + zero/sign extend, and
// (with LIMN2600_BUS_RMW_EN) store merge of sub-word data into a read word.
module limn2600_lane_align
    import limn2600_bus_pkg::*;
(
    input  logic [1:0]            addr_lo,
    input  size_e                 size,
    input  logic                  sgn,
    input  logic [BUS_DATA_W-1:0] rdata,
`ifdef LIMN2600_BUS_RMW_EN
    input  logic [BUS_DATA_W-1:0] wdata,
    output logic [BUS_DATA_W-1:0] merged,
`endif
    output logic [BUS_DATA_W-1:0] load_data
);

    logic [BUS_DATA_W-1:0] shifted;

    // Little-endian: the addressed byte lane is shifted down to bit 0
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        load_data = shifted;
        case (size)
            SZ_BYTE: load_data = sgn ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'h0, shifted[7:0]};
            SZ_HALF: load_data = sgn ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

`ifdef LIMN2600_BUS_RMW_EN
    // Replace only the addressed lane(s); halves are known to be aligned here
    always_comb begin
        merged = rdata;
        case (size)
            SZ_BYTE: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end
`endif

endmodule

// File: rtl/limn2600_bus_master.sv
// Limn2600 single-word bus initiator. One request in flight; one-cycle cs
// strobe per bus phase, rdy-or-timeout completion, one response pulse.
// Optional feature macro: LIMN2600_BUS_RMW_EN (sub-word stores via read-modify-write).
module limn2600_bus_master
    import limn2600_bus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [BUS_DATA_W-1:0] req_addr,
    input  logic [BUS_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [BUS_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  bus_cs,
    output logic                  bus_we,
    output logic [BUS_DATA_W-1:0] bus_addr,
    output logic [BUS_DATA_W-1:0] bus_wdata,
    input  logic                  bus_rdy,
    input  logic [BUS_DATA_W-1:0] bus_rdata
);

    state_t                state;
    req_t                  r;
    logic [7:0]            wait_cnt;
    logic [BUS_DATA_W-1:0] load_data;
    logic                  in_bus;
`ifdef LIMN2600_BUS_RMW_EN
    logic [BUS_DATA_W-1:0] merged;
`endif

    assign req_ready = (state == ST_IDLE) && !rst;
    assign in_bus    = (state == ST_RD) || (state == ST_WR) ||
                       (state == ST_RMW_RD) || (state == ST_RMW_WR);

    limn2600_lane_align u_align (
        .addr_lo   (r.addr[1:0]),
        .size      (r.size),
        .sgn       (r.sgn),
        .rdata     (bus_rdata),
`ifdef LIMN2600_BUS_RMW_EN
        .wdata     (r.wdata),
        .merged    (merged),
`endif
        .load_data (load_data)
    );

    // Request FSM; bus_cs and rsp_valid are single-cycle pulses by default-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            r         <= '0;
            wait_cnt  <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            bus_cs    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            bus_cs    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r        <= '{we: req_we, size: size_e'(req_size), sgn: req_signed,
                                      addr: req_addr, wdata: req_wdata};
                        bus_addr <= {req_addr[31:2], 2'b00};
                        wait_cnt <= 8'd0;
                        if (req_bad(size_e'(req_size), req_addr[1:0], req_we)) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (!req_we) begin
                            state  <= ST_RD;
                            bus_cs <= 1'b1;
                            bus_we <= 1'b0;
                        end else if (size_e'(req_size) == SZ_WORD) begin
                            state     <= ST_WR;
                            bus_cs    <= 1'b1;
                            bus_we    <= 1'b1;
                            bus_wdata <= req_wdata;
                        end else begin
`ifdef LIMN2600_BUS_RMW_EN
                            state  <= ST_RMW_RD;
                            bus_cs <= 1'b1;
                            bus_we <= 1'b0;
`else
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
`endif
                        end
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: begin
                    // rdy only counts after the cs cycle of the current phase
                    if (in_bus && !bus_cs) begin
                        if (bus_rdy) begin
`ifdef LIMN2600_BUS_RMW_EN
                            if (state == ST_RMW_RD) begin
                                state     <= ST_RMW_WR;
                                bus_cs    <= 1'b1;
                                bus_we    <= 1'b1;
                                bus_wdata <= merged;
                                wait_cnt  <= 8'd0;
                            end else
`endif
                            begin
                                state     <= ST_RESP;
                                rsp_valid <= 1'b1;
                                bus_we    <= 1'b0;
                                if (state == ST_RD)
                                    rsp_rdata <= load_data;
                            end
                        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            bus_we    <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else if (!in_bus) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
